// File: rtl/long_div_seq.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define CPU_DIV_SIGNED_EN to honour in_signed (truncating signed divide); default build is unsigned only.
module long_div_seq #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_a,
  input  logic [WORD_WIDTH-1:0] in_b,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_quot,
  output logic [WORD_WIDTH-1:0] out_rem,
  output logic                  out_div_zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_CNT_INIT = CNT_WIDTH'(WORD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(1);

  state_t r_state;
  state_t w_state_next;

  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [WORD_WIDTH-1:0] r_dvd;
  logic [WORD_WIDTH-1:0] r_dvs;
  logic [WORD_WIDTH-1:0] r_rem;
  logic [WORD_WIDTH-1:0] r_quot;
  logic                  r_q_neg;
  logic                  r_r_neg;
  logic [WORD_WIDTH-1:0] r_out_quot;
  logic [WORD_WIDTH-1:0] r_out_rem;
  logic                  r_div_zero;

  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_accept;
  logic                  w_b_zero;
  logic                  w_sgn;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [WORD_WIDTH-1:0] w_a_mag;
  logic [WORD_WIDTH-1:0] w_b_mag;
  logic [WORD_WIDTH:0]   w_partial;
  logic                  w_ge;
  logic [WORD_WIDTH-1:0] w_diff;
  logic [WORD_WIDTH-1:0] w_quot_fix;
  logic [WORD_WIDTH-1:0] w_rem_fix;

`ifdef CPU_DIV_SIGNED_EN
  assign w_sgn = in_signed;
`else
  // Signed requests are treated as unsigned; the input is still referenced so it is not left dangling.
  assign w_sgn = in_signed & 1'b0;
`endif

  assign w_a_neg  = w_sgn & in_a[WORD_WIDTH-1];
  assign w_b_neg  = w_sgn & in_b[WORD_WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~in_a + 1'b1) : in_a;
  assign w_b_mag  = w_b_neg ? (~in_b + 1'b1) : in_b;
  assign w_b_zero = (in_b == '0);
  assign w_accept = in_valid & w_in_ready;

  // Partial remainder never exceeds the divisor width once the subtract decision is made.
  assign w_partial = {r_rem, r_dvd[WORD_WIDTH-1]};
  assign w_ge      = (w_partial >= {1'b0, r_dvs});
  assign w_diff    = w_partial[WORD_WIDTH-1:0] - r_dvs;

  assign w_quot_fix = r_q_neg ? (~r_quot + 1'b1) : r_quot;
  assign w_rem_fix  = r_r_neg ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_b_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LP_CNT_LAST) begin
          w_state_next = S_FIXUP;
        end
      end
      S_FIXUP: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_out_quot <= '0;
      r_out_rem  <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd      <= w_a_mag;
            r_dvs      <= w_b_mag;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= LP_CNT_INIT;
            r_q_neg    <= w_a_neg ^ w_b_neg;
            r_r_neg    <= w_a_neg;
            r_div_zero <= w_b_zero;
            // Divide-by-zero bypasses the loop and reports the raw dividend.
            if (w_b_zero) begin
              r_out_quot <= '1;
              r_out_rem  <= in_a;
            end
          end
        end
        S_CALC: begin
          r_rem  <= w_ge ? w_diff : w_partial[WORD_WIDTH-1:0];
          r_quot <= {r_quot[WORD_WIDTH-2:0], w_ge};
          r_dvd  <= {r_dvd[WORD_WIDTH-2:0], 1'b0};
          r_cnt  <= r_cnt - 1'b1;
        end
        S_FIXUP: begin
          r_out_quot <= w_quot_fix;
          r_out_rem  <= w_rem_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign out_quot     = r_out_quot;
  assign out_rem      = r_out_rem;
  assign out_div_zero = r_div_zero;

endmodule

// File: tb/tb_long_div_seq.sv
// Directed self-checking bench for long_div_seq at the default 32-bit width.
module tb_long_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quot;
  logic [31:0] out_rem;
  logic        out_div_zero;

  int checks;
  int errors;
  int lat;
  int ready_viol;
  int stable_viol;
  logic [31:0] q_hold;
  logic [31:0] r_hold;

  long_div_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_signed    (in_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quot     (out_quot),
    .out_rem      (out_rem),
    .out_div_zero (out_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then scramble the inputs to prove they were latched.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_a      = $urandom;
    in_b      = $urandom;
    in_signed = 1'b0;
    $display("accept a=0x%08h b=0x%08h signed=%0d", a, b, s);
  endtask

  // Counts edges from the accept (inclusive) until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 1;
    ready_viol = 0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) ready_viol++;
      @(posedge clk);
      #1;
      n++;
    end
    $display("result q=0x%08h r=0x%08h dz=%0d latency=%0d", out_quot, out_rem, out_div_zero, n);
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
    check("consume_valid", {63'd0, out_valid}, 64'd0);
    check("consume_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_quot", {32'd0, out_quot}, 64'd0);
    check("rst_rem", {32'd0, out_rem}, 64'd0);
    check("rst_dz", {63'd0, out_div_zero}, 64'd0);

    // 100 / 7
    start(32'd100, 32'd7, 1'b0);
    wait_valid(lat);
    check("u100_7_latency", 64'(lat), 64'd34);
    check("u100_7_ready_low", 64'(ready_viol), 64'd0);
    check("u100_7_quot", {32'd0, out_quot}, 64'd14);
    check("u100_7_rem", {32'd0, out_rem}, 64'd2);
    check("u100_7_dz", {63'd0, out_div_zero}, 64'd0);
    consume();

    // Divide by zero
    start(32'h1234_5678, 32'd0, 1'b0);
    wait_valid(lat);
    check("dz_latency", 64'(lat), 64'd1);
    check("dz_quot", {32'd0, out_quot}, 64'hFFFF_FFFF);
    check("dz_rem", {32'd0, out_rem}, 64'h1234_5678);
    check("dz_flag", {63'd0, out_div_zero}, 64'd1);
    consume();

    // Back-pressure for 10 cycles
    out_ready = 1'b0;
    start(32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd34);
    check("bp_dz_cleared", {63'd0, out_div_zero}, 64'd0);
    q_hold = out_quot;
    r_hold = out_rem;
    stable_viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quot !== q_hold || out_rem !== r_hold)
        stable_viol++;
    end
    check("bp_stable", 64'(stable_viol), 64'd0);
    check("bp_quot", {32'd0, out_quot}, 64'h0FFF_FFFF);
    check("bp_rem", {32'd0, out_rem}, 64'hF);
    @(negedge clk);
    out_ready = 1'b1;
    consume();

    // Reset in the middle of CALC
    start(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_quot", {32'd0, out_quot}, 64'd0);
    check("midrst_rem", {32'd0, out_rem}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start(32'd9, 32'd2, 1'b0);
    wait_valid(lat);
    check("u9_2_latency", 64'(lat), 64'd34);
    check("u9_2_quot", {32'd0, out_quot}, 64'd4);
    check("u9_2_rem", {32'd0, out_rem}, 64'd1);
    consume();

    // Dividend smaller than divisor, and divide by one
    start(32'd5, 32'd9, 1'b0);
    wait_valid(lat);
    check("u5_9_quot", {32'd0, out_quot}, 64'd0);
    check("u5_9_rem", {32'd0, out_rem}, 64'd5);
    consume();
    start(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_valid(lat);
    check("umax_1_quot", {32'd0, out_quot}, 64'hFFFF_FFFF);
    check("umax_1_rem", {32'd0, out_rem}, 64'd0);
    consume();

    // Signed requests: -7/2 and MIN/-1
    start(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_valid(lat);
`ifdef CPU_DIV_SIGNED_EN
    check("s_m7_2_quot", {32'd0, out_quot}, 64'hFFFF_FFFD);
    check("s_m7_2_rem", {32'd0, out_rem}, 64'hFFFF_FFFF);
`else
    check("s_m7_2_quot", {32'd0, out_quot}, 64'h7FFF_FFFC);
    check("s_m7_2_rem", {32'd0, out_rem}, 64'd1);
`endif
    consume();
    start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_valid(lat);
`ifdef CPU_DIV_SIGNED_EN
    check("s_min_m1_quot", {32'd0, out_quot}, 64'h8000_0000);
    check("s_min_m1_rem", {32'd0, out_rem}, 64'd0);
`else
    check("s_min_m1_quot", {32'd0, out_quot}, 64'd0);
    check("s_min_m1_rem", {32'd0, out_rem}, 64'h8000_0000);
`endif
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
